dmem_responder: RTL and testbench

// Data-memory responder for the RV32I core's data bus. Answers the core's load/store

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for RV32I loads/stores: fixed-latency request/ready handshake,
// byte-lane select with sign/zero extension, and fault reporting on a shared data bus.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              drw,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] daddr,
  inout  wire  [31:0]       ddata,
  output logic              ready,
  output logic              fault,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                drw_r;
  logic [2:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [3:0]          cnt_r;
  logic [31:0]         rdata_r;
  logic                drive_r;
  logic [31:0]         mem [DEPTH_WORDS];

  logic [ADDR_W-3:0]   word_idx_s;
  logic                size_bad_s;
  logic                range_bad_s;
  logic                illegal_s;
  logic [31:0]         mem_word_s;
  logic                do_read_s;
  logic                do_write_s;

  // Extract the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [2:0] sz,
                                            input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'h000000, b};
      3'd5:    res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Merge store data into the old word; untouched lanes keep their contents.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                              input logic [2:0] sz, input logic [1:0] off);
    logic [31:0] res;
    res = old_word;
    case (sz)
      3'd0:    res[{off, 3'b000} +: 8] = wd[7:0];
      3'd1:    res[{off[1], 4'b0000} +: 16] = wd[15:0];
      3'd2:    res = wd;
      default: res = old_word;
    endcase
    return res;
  endfunction

  assign word_idx_s  = addr_r[ADDR_W-1:2];
  assign range_bad_s = ({2'b00, word_idx_s} >= DEPTH_LIM);
  assign illegal_s   = size_bad_s | range_bad_s;
  assign do_read_s   = (state_r == ST_ACCESS) && !illegal_s && !drw_r;
  assign do_write_s  = (state_r == ST_ACCESS) && !illegal_s && drw_r;
  assign ddata       = drive_r ? rdata_r : 32'bz;

  // Size/alignment legality of the latched request.
  always_comb begin
    size_bad_s = 1'b0;
    case (size_r)
      3'd0:    size_bad_s = 1'b0;
      3'd1:    size_bad_s = addr_r[0];
      3'd2:    size_bad_s = addr_r[1] | addr_r[0];
      3'd4:    size_bad_s = drw_r;
      3'd5:    size_bad_s = drw_r | addr_r[0];
      default: size_bad_s = 1'b1;
    endcase
  end

  // Array read is guarded so an out-of-range index never selects a missing word.
  always_comb begin
    mem_word_s = 32'h0000_0000;
    if (range_bad_s) begin
      mem_word_s = 32'h0000_0000;
    end else begin
      mem_word_s = mem[word_idx_s];
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          next_state_s = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ACCESS:  next_state_s = ST_RESPOND;
      ST_RESPOND: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // State, request latches and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      drw_r   <= 1'b0;
      size_r  <= 3'd0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      cnt_r   <= 4'd0;
      rdata_r <= 32'h0000_0000;
      drive_r <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy    <= (next_state_s != ST_IDLE);
      ready   <= (state_r == ST_ACCESS);
      fault   <= (state_r == ST_ACCESS) && illegal_s;
      drive_r <= do_read_s;
      if (state_r == ST_IDLE && req) begin
        drw_r   <= drw;
        size_r  <= size;
        addr_r  <= daddr;
        wdata_r <= ddata;
        cnt_r   <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (do_read_s) begin
        rdata_r <= load_lane(mem_word_s, size_r, addr_r[1:0]);
      end
    end
  end

  // Store commit on the ACCESS exit edge; a coincident reset drops it.
  always_ff @(posedge clk) begin
    if (!rst && do_write_s) begin
      mem[word_idx_s] <= store_merge(mem_word_s, wdata_r, size_r, addr_r[1:0]);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int AW      = 12;
  localparam int DEPTH_A = 1000;
  localparam int WS_B    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, drw_a, tb_drv;
  logic [2:0]    size_a;
  logic [AW-1:0] addr_a;
  logic [31:0]   tb_wd;
  wire  [31:0]   ddata_a;
  logic          ready_a, fault_a, busy_a;
  logic          req_b, drw_b;
  logic [2:0]    size_b;
  logic [AW-1:0] addr_b;
  wire  [31:0]   ddata_b;
  logic          ready_b, fault_b, busy_b;

  logic [31:0]   mdl [DEPTH_A];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;
  assign ddata_a = tb_drv ? tb_wd : 32'bz;

  dmem_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH_A), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .drw(drw_a), .size(size_a), .daddr(addr_a),
    .ddata(ddata_a), .ready(ready_a), .fault(fault_a), .busy(busy_a)
  );

  dmem_responder #(.ADDR_W(AW), .DEPTH_WORDS(1024), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .drw(drw_b), .size(size_b), .daddr(addr_b),
    .ddata(ddata_b), .ready(ready_b), .fault(fault_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit exp_illegal(input bit w, input logic [2:0] sz, input logic [AW-1:0] a);
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) return 1'b1;
    if (w && (sz == 3'd4 || sz == 3'd5)) return 1'b1;
    if ((sz == 3'd1 || sz == 3'd5) && (a % 2) != 0) return 1'b1;
    if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
    return (int'(a) / 4) >= DEPTH_A;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] sz,
                                           input logic [AW-1:0] a);
    logic [31:0] b, h;
    b = (word >> ((a % 4) * 8)) & 32'h0000_00FF;
    h = (word >> (((a / 2) % 2) * 16)) & 32'h0000_FFFF;
    case (sz)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    case (sz)
      3'd0:    begin sh = (a % 4) * 8;         mask = 32'h0000_00FF; end
      3'd1:    begin sh = ((a / 2) % 2) * 16;  mask = 32'h0000_FFFF; end
      default: begin sh = 0;                   mask = 32'hFFFF_FFFF; end
    endcase
    mdl[a / 4] = (mdl[a / 4] & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  // Called at a negedge with DUT A idle; returns at the negedge one cycle after ready.
  task automatic xact(input bit w, input logic [2:0] sz, input logic [AW-1:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    bit ill;
    int lat;
    ill = exp_illegal(w, sz, a);
    rd = 32'h0;
    flt = 1'b0;
    req_a = 1'b1; drw_a = w; size_a = sz; addr_a = a; tb_wd = wd; tb_drv = w;
    @(posedge clk);
    #1;
    req_a = 1'b0; tb_drv = 1'b0;
    drw_a = 1'($urandom); size_a = 3'($urandom); addr_a = AW'($urandom);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("busy_after_accept", {31'b0, busy_a}, 32'd1);
      if (ready_a) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", lat, 32'd2);
    if (lat != 0) begin
      flt = fault_a;
      check_eq("fault", {31'b0, fault_a}, {31'b0, ill});
      if (!ill && !w) begin
        rd = ddata_a;
        check_eq("rdata", ddata_a, exp_load(mdl[a / 4], sz, a));
      end
    end
    if (!ill && w) model_store(sz, a, wd);
    @(negedge clk);
    check_eq("idle_after", {30'b0, ready_a, busy_a}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    logic        seen;
    bit          exp_rdy, exp_busy;

    rst = 1'b1;
    req_a = 1'b0; drw_a = 1'b0; size_a = 3'd0; addr_a = '0; tb_drv = 1'b0; tb_wd = 32'h0;
    req_b = 1'b0; drw_b = 1'b0; size_b = 3'd2; addr_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_a", {29'b0, ready_a, fault_a, busy_a}, 32'd0);
    check_eq("reset_b", {29'b0, ready_b, fault_b, busy_b}, 32'd0);
    rst = 1'b0;

    // Initialise every word the random phase may read.
    for (int i = 0; i < 16; i++) xact(1'b1, 3'd2, AW'(i * 4), $urandom, rd, flt);
    for (int i = 990; i < DEPTH_A; i++) xact(1'b1, 3'd2, AW'(i * 4), $urandom, rd, flt);

    xact(1'b1, 3'd2, 12'h010, 32'hDEAD_BEEF, rd, flt);
    xact(1'b0, 3'd2, 12'h010, 32'h0, rd, flt);
    check_eq("t1_lw", rd, 32'hDEAD_BEEF);

    xact(1'b1, 3'd0, 12'h013, 32'h1234_5680, rd, flt);
    xact(1'b0, 3'd0, 12'h013, 32'h0, rd, flt);
    check_eq("t2_lb", rd, 32'hFFFF_FF80);
    xact(1'b0, 3'd4, 12'h013, 32'h0, rd, flt);
    check_eq("t2_lbu", rd, 32'h0000_0080);
    xact(1'b0, 3'd2, 12'h010, 32'h0, rd, flt);
    check_eq("t2_lw", rd, 32'h80AD_BEEF);

    xact(1'b1, 3'd1, 12'h012, 32'hABCD_1234, rd, flt);
    xact(1'b0, 3'd5, 12'h012, 32'h0, rd, flt);
    check_eq("t3_lhu", rd, 32'h0000_1234);
    xact(1'b0, 3'd1, 12'h011, 32'h0, rd, flt);
    check_eq("t3_lh_misaligned", {31'b0, flt}, 32'd1);
    xact(1'b0, 3'd2, 12'h010, 32'h0, rd, flt);
    check_eq("t3_lw", rd, 32'h1234_BEEF);

    xact(1'b0, 3'd3, 12'h010, 32'h0, rd, flt);
    check_eq("t4_size3", {31'b0, flt}, 32'd1);
    xact(1'b1, 3'd4, 12'h010, 32'hFFFF_FFFF, rd, flt);
    check_eq("t4_sbu", {31'b0, flt}, 32'd1);
    xact(1'b0, 3'd2, 12'hFFE, 32'h0, rd, flt);
    check_eq("t4_lw_ffe", {31'b0, flt}, 32'd1);
    xact(1'b0, 3'd2, 12'hFA0, 32'h0, rd, flt);
    check_eq("t4_first_oob", {31'b0, flt}, 32'd1);
    xact(1'b0, 3'd2, 12'hF9C, 32'h0, rd, flt);
    check_eq("t4_last_word", {31'b0, flt}, 32'd0);
    xact(1'b0, 3'd2, 12'h010, 32'h0, rd, flt);
    check_eq("t4_lw_unchanged", rd, 32'h1234_BEEF);

    // Reset lands on the edge that would commit the store.
    xact(1'b1, 3'd2, 12'h020, 32'h0BAD_F00D, rd, flt);
    req_a = 1'b1; drw_a = 1'b1; size_a = 3'd2; addr_a = 12'h020; tb_wd = 32'h5555_5555; tb_drv = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_after_rst", {30'b0, ready_a, busy_a}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ready_a;
    end
    check_eq("t5_no_ready", {31'b0, seen}, 32'd0);
    xact(1'b0, 3'd2, 12'h020, 32'h0, rd, flt);
    check_eq("t5_old_value", rd, 32'h0BAD_F00D);

    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(990, 1005) * 4 + $urandom_range(0, 3));
      else a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, flt);
    end

    // Back-to-back reads on the wait-state instance with req held high.
    @(negedge clk);
    req_b = 1'b1; drw_b = 1'b0; size_b = 3'd2; addr_b = 12'h040;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      exp_rdy  = (c % 6 == 5);
      exp_busy = (c % 6 != 0);
      check_eq($sformatf("t6_cycle%0d", c), {30'b0, ready_b, busy_b}, {30'b0, exp_rdy, exp_busy});
      if (exp_rdy) check_eq("t6_fault", {31'b0, fault_b}, 32'd0);
      addr_b = AW'($urandom_range(0, 1023) * 4);
      if (c == 23) req_b = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
